// File: rtl/char_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : char_buffer_arbiter
// Description : Round-robin arbiter for three character-buffer writers, with a
//               full-screen clear sweep, gated to the VGA vertical blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module char_buffer_arbiter #(
    parameter int NUM_COLS   = 40,
    parameter int NUM_ROWS   = 15,
    parameter int V_ACTIVE   = 480,
    parameter int CLEAR_CODE = 0
) (
    input  logic        VGA_clk,
    input  logic        reset_n,
    input  logic [9:0]  yPixel,
    input  logic [2:0]  req,
    input  logic [17:0] req_x,
    input  logic [11:0] req_y,
    input  logic [23:0] req_code,
    input  logic        clr_req,
    output logic [2:0]  gnt,
    output logic [2:0]  err,
    output logic        busy,
    output logic        wr_en,
    output logic [5:0]  wr_x,
    output logic [3:0]  wr_y,
    output logic [7:0]  wr_data
);

    localparam logic [6:0] c_num_cols   = 7'(NUM_COLS);
    localparam logic [4:0] c_num_rows   = 5'(NUM_ROWS);
    localparam logic [5:0] c_last_col   = 6'(NUM_COLS - 1);
    localparam logic [3:0] c_last_row   = 4'(NUM_ROWS - 1);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [7:0] c_clear_code = 8'(CLEAR_CODE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic        clr_pending_q;
    logic [5:0]  cx_q;
    logic [3:0]  cy_q;
    logic [2:0]  gnt_q;
    logic [2:0]  err_q;
    logic        wr_en_q;
    logic [5:0]  wr_x_q;
    logic [3:0]  wr_y_q;
    logic [7:0]  wr_data_q;

    logic        w_win;
    logic        w_busy;
    logic        w_any;
    logic [1:0]  w_sel;
    logic        w_in_range;
    logic [5:0]  w_x_a    [3];
    logic [3:0]  w_y_a    [3];
    logic [7:0]  w_code_a [3];

    function automatic logic [1:0] f_wrap(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign w_x_a[gi]    = req_x[6*gi +: 6];
        assign w_y_a[gi]    = req_y[4*gi +: 4];
        assign w_code_a[gi] = req_code[8*gi +: 8];
    end

    assign w_win  = (yPixel >= c_v_active);
    assign w_busy = clr_pending_q | (state_q == S_CLEAR);

    // Scan from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (req[f_wrap({1'b0, ptr_q} + 3'(k))]) begin
                w_any = 1'b1;
                w_sel = f_wrap({1'b0, ptr_q} + 3'(k));
            end
        end
    end

    assign w_in_range = ({1'b0, w_x_a[w_sel]} < c_num_cols) &&
                        ({1'b0, w_y_a[w_sel]} < c_num_rows);

    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd0;
            clr_pending_q <= 1'b0;
            cx_q          <= 6'd0;
            cy_q          <= 4'd0;
            gnt_q         <= 3'd0;
            err_q         <= 3'd0;
            wr_en_q       <= 1'b0;
            wr_x_q        <= 6'd0;
            wr_y_q        <= 4'd0;
            wr_data_q     <= 8'd0;
        end else begin
            gnt_q   <= 3'd0;
            err_q   <= 3'd0;
            wr_en_q <= 1'b0;
            if (clr_req && !w_busy) begin
                clr_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (clr_pending_q && w_win) begin
                        state_q <= S_CLEAR;
                    end else if (w_win && w_any) begin
                        state_q <= S_WRITE;
                        gnt_q   <= 3'b001 << w_sel;
                        ptr_q   <= f_wrap({1'b0, w_sel} + 3'd1);
                        if (w_in_range) begin
                            wr_en_q   <= 1'b1;
                            wr_x_q    <= w_x_a[w_sel];
                            wr_y_q    <= w_y_a[w_sel];
                            wr_data_q <= w_code_a[w_sel];
                        end else begin
                            err_q <= 3'b001 << w_sel;
                        end
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                end
                S_CLEAR: begin
                    // Outside the window the sweep position simply holds.
                    if (w_win) begin
                        wr_en_q   <= 1'b1;
                        wr_x_q    <= cx_q;
                        wr_y_q    <= cy_q;
                        wr_data_q <= c_clear_code;
                        if (cx_q == c_last_col) begin
                            cx_q <= 6'd0;
                            if (cy_q == c_last_row) begin
                                cy_q          <= 4'd0;
                                clr_pending_q <= 1'b0;
                                state_q       <= S_IDLE;
                            end else begin
                                cy_q <= cy_q + 4'd1;
                            end
                        end else begin
                            cx_q <= cx_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign err     = err_q;
    assign busy    = w_busy;
    assign wr_en   = wr_en_q;
    assign wr_x    = wr_x_q;
    assign wr_y    = wr_y_q;
    assign wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_buffer_arbiter
// Description : Directed bench for char_buffer_arbiter with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_buffer_arbiter;

    localparam int COLS = 40;
    localparam int ROWS = 15;
    localparam int VACT = 480;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  yPixel = '0;
    logic [2:0]  req = '0;
    logic [17:0] req_x = '0;
    logic [11:0] req_y = '0;
    logic [23:0] req_code = '0;
    logic        clr_req = 1'b0;
    logic [2:0]  gnt;
    logic [2:0]  err;
    logic        busy;
    logic        wr_en;
    logic [5:0]  wr_x;
    logic [3:0]  wr_y;
    logic [7:0]  wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    char_buffer_arbiter dut (
        .VGA_clk  (clk),
        .reset_n  (reset_n),
        .yPixel   (yPixel),
        .req      (req),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_code (req_code),
        .clr_req  (clr_req),
        .gnt      (gnt),
        .err      (err),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 write, 2 clear; clear progress is a
    // linear cell number converted to (x, y) with div/mod.
    int         m_mode;
    int         m_next;
    int         m_cell;
    bit         m_pend;
    logic [2:0] e_gnt;
    logic [2:0] e_err;
    logic       e_wr_en;
    logic [5:0] e_x;
    logic [3:0] e_y;
    logic [7:0] e_d;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_next = 0; m_cell = 0; m_pend = 0;
            e_gnt = 0; e_err = 0; e_wr_en = 0; e_x = 0; e_y = 0; e_d = 0;
        end else begin
            bit win;
            bit pend_n;
            int who;
            int rx;
            int ry;
            win    = (int'(yPixel) >= VACT);
            pend_n = m_pend || (clr_req && !(m_pend || m_mode == 2));
            e_gnt = 0; e_err = 0; e_wr_en = 0;
            if (m_mode == 0) begin
                if (m_pend && win) begin
                    m_mode = 2;
                end else if (win && req != 0) begin
                    who = -1;
                    for (int k = 0; k < 3; k++) begin
                        if (who < 0 && req[(m_next + k) % 3]) who = (m_next + k) % 3;
                    end
                    m_mode = 1;
                    m_next = (who + 1) % 3;
                    e_gnt[who] = 1'b1;
                    rx = int'(req_x[6*who +: 6]);
                    ry = int'(req_y[4*who +: 4]);
                    if (rx < COLS && ry < ROWS) begin
                        e_wr_en = 1; e_x = 6'(rx); e_y = 4'(ry);
                        e_d = req_code[8*who +: 8];
                    end else begin
                        e_err[who] = 1'b1;
                    end
                end
            end else if (m_mode == 1) begin
                m_mode = 0;
            end else if (win) begin
                e_wr_en = 1; e_x = 6'(m_cell % COLS); e_y = 4'(m_cell / COLS); e_d = 0;
                m_cell++;
                if (m_cell == COLS * ROWS) begin
                    m_cell = 0; pend_n = 0; m_mode = 0;
                end
            end
            m_pend = pend_n;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_gnt", 32'(gnt), 32'(e_gnt));
            chk("m_err", 32'(err), 32'(e_err));
            chk("m_wr_en", 32'(wr_en), 32'(e_wr_en));
            chk("m_busy", 32'(busy), 32'(m_pend || m_mode == 2));
            chk("m_wr_x", 32'(wr_x), 32'(e_x));
            chk("m_wr_y", 32'(wr_y), 32'(e_y));
            chk("m_wr_data", 32'(wr_data), 32'(e_d));
        end
    end

    task automatic set_req(input int i, input int x, input int y, input int code);
        req_x[6*i +: 6]    = 6'(x);
        req_y[4*i +: 4]    = 4'(y);
        req_code[8*i +: 8] = 8'(code);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wr_x"}, 32'(wr_x), 0);
        chk({tag, "_wr_y"}, 32'(wr_y), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    initial begin
        int  n;
        int  cyc;
        bit  done;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset_n = 1'b1;

        // Single in-range request
        yPixel = 10'd480; set_req(0, 26, 1, 84); req = 3'b001;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'b001);
        chk("single_wr_en", 32'(wr_en), 1);
        chk("single_wr_x", 32'(wr_x), 26);
        chk("single_wr_y", 32'(wr_y), 1);
        chk("single_wr_data", 32'(wr_data), 84);
        req = 3'b000;
        @(negedge clk);
        chk("single_after_gnt", 32'(gnt), 0);
        chk("single_after_wr_en", 32'(wr_en), 0);
        chk("single_hold_x", 32'(wr_x), 26);

        // Hold-off during the active area
        yPixel = 10'd100; set_req(1, 5, 2, 65); req = 3'b010;
        repeat (4) begin
            @(negedge clk);
            chk("holdoff_gnt", 32'(gnt), 0);
        end
        yPixel = 10'd479;
        @(negedge clk);
        chk("holdoff_479_gnt", 32'(gnt), 0);
        yPixel = 10'd480;
        @(negedge clk);
        chk("holdoff_gnt_window", 32'(gnt), 32'b010);
        chk("holdoff_wr_x", 32'(wr_x), 5);
        req = 3'b000;
        @(negedge clk);

        // Round-robin from a fresh pointer
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_req(0, 1, 0, 10); set_req(1, 2, 1, 11); set_req(2, 3, 2, 12);
        req = 3'b111;
        @(negedge clk); chk("rr_g0", 32'(gnt), 32'b001); chk("rr_g0_x", 32'(wr_x), 1);
        @(negedge clk); chk("rr_gap0", 32'(gnt), 0);
        @(negedge clk); chk("rr_g1", 32'(gnt), 32'b010); chk("rr_g1_x", 32'(wr_x), 2);
        @(negedge clk); chk("rr_gap1", 32'(gnt), 0);
        @(negedge clk); chk("rr_g2", 32'(gnt), 32'b100); chk("rr_g2_x", 32'(wr_x), 3);
        @(negedge clk); chk("rr_gap2", 32'(gnt), 0);
        @(negedge clk); chk("rr_g3", 32'(gnt), 32'b001);
        req = 3'b000;
        @(negedge clk);

        // Out-of-range coordinates, then the last valid cell
        set_req(2, 40, 3, 77); req = 3'b100;
        @(negedge clk);
        chk("oor_x_gnt", 32'(gnt), 32'b100);
        chk("oor_x_err", 32'(err), 32'b100);
        chk("oor_x_wr_en", 32'(wr_en), 0);
        req = 3'b000;
        @(negedge clk);
        set_req(2, 5, 15, 78); req = 3'b100;
        @(negedge clk);
        chk("oor_y_gnt", 32'(gnt), 32'b100);
        chk("oor_y_err", 32'(err), 32'b100);
        chk("oor_y_wr_en", 32'(wr_en), 0);
        req = 3'b000;
        @(negedge clk);
        set_req(2, 39, 14, 79); req = 3'b100;
        @(negedge clk);
        chk("edge_cell_err", 32'(err), 0);
        chk("edge_cell_wr_en", 32'(wr_en), 1);
        chk("edge_cell_xy", 32'({wr_x, wr_y}), 32'({6'd39, 4'd14}));
        req = 3'b000;
        @(negedge clk);

        // Clear requested just before the window with req[0] pending
        yPixel = 10'd479; set_req(0, 7, 7, 9); req = 3'b001; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        chk("clr_busy_set", 32'(busy), 1);
        chk("clr_no_gnt", 32'(gnt), 0);
        yPixel = 10'd480;
        n = 0; cyc = 0; done = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            yPixel = (cyc >= 100 && cyc < 106) ? 10'd200 : 10'd480;
            clr_req = (cyc == 50);
            if (wr_en) begin
                chk("sweep_x", 32'(wr_x), 32'(n % COLS));
                chk("sweep_y", 32'(wr_y), 32'(n / COLS));
                chk("sweep_data", 32'(wr_data), 0);
                chk("sweep_no_gnt", 32'(gnt), 0);
                n++;
            end
            if (!busy) done = 1;
        end
        clr_req = 1'b0;
        chk("clear_done", 32'(done), 1);
        chk("clear_count", 32'(n), 600);
        chk("clear_last_xy", 32'({wr_x, wr_y}), 32'({6'd39, 4'd14}));
        @(negedge clk);
        chk("post_clear_gnt", 32'(gnt), 32'b001);
        chk("post_clear_wr_x", 32'(wr_x), 7);
        req = 3'b000;
        @(negedge clk);

        // Reset in the middle of a sweep
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_reset_busy", 32'(busy), 0);
            chk("post_reset_wr_en", 32'(wr_en), 0);
            chk("post_reset_wr_x", 32'(wr_x), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
